conv_window_gen: RTL and testbench
==================================

// Module: conv_window_gen
// PURPOSE
//  Line-buffer controller and KxK sliding-window generator for the conv datapath.
//  - Accepts a raster-order pixel stream (valid/ready) and shifts it through a chain of KERNEL-1 row delay elements.
//  - Shifts the columns into a KxK window register.
//  - Emits one full window per valid (no-padding) output position to the MAC array, with a valid/ready handshake.
// PARAMETERS
//  BIT_WIDTH  16  bits per pixel
//  IMG_W      16  frame width in pixels; must be >= KERNEL
//  IMG_H      16  frame height in pixels; must be >= KERNEL
//  KERNEL     3   window edge; must be >= 2
// PORTS
//  clk         in   1                      system clock
//  rst         in   1                      reset, asynchronous, active-high
//  in_valid    in   1                      input pixel valid
//  in_ready    out  1                      input pixel accepted when in_valid & in_ready
//  in_data     in   BIT_WIDTH              input pixel, raster order, row-major
//  out_valid   out  1                      window valid
//  out_ready   in   1                      consumer accepts window
//  out_window  out  KERNEL*KERNEL*BIT_WIDTH  element (r,c) at [(r*KERNEL+c)*BIT_WIDTH +: BIT_WIDTH]
//  out_last    out  1                      qualifies the last window of a frame
// BEHAVIOUR
//  - Reset values: out_valid=0, out_last=0, out_window=0, col_cnt=0, row_cnt=0.
//    Row-delay storage and the window register are not reset.
//  - Handshake: in_ready = !out_valid | out_ready (combinational).
//    in_valid=1 with in_ready=0 leaves all state unchanged.
//  - On accept (in_valid & in_ready):
//    - Row delays advance one step; tap i presents the pixel accepted i*IMG_W accepts earlier.
//    - Window register shifts left one column.
//    - The new column (c=KERNEL-1) is loaded with: r=KERNEL-1 <- in_data; r=KERNEL-2 <- tap1; ...; r=0 <- tap(KERNEL-1).
//    - (0,0) is the oldest pixel; (K-1,K-1) is the newest.
//  - Counters: col_cnt increments per accept and wraps at IMG_W-1, where row_cnt increments.
//    row_cnt wraps to 0 after (IMG_H-1, IMG_W-1). The next accept is pixel (0,0) of the next frame.
//  - Emit: an accept at (row_cnt>=KERNEL-1 && col_cnt>=KERNEL-1) sets out_valid=1 the next cycle (latency 1).
//    out_window then holds the window ending at that pixel.
//  - out_last=1 together with the window emitted for pixel (IMG_H-1, IMG_W-1).
//  - out_valid clears on out_ready unless a new window is emitted in the same cycle.
//    Simultaneous drain and emit: out_valid stays 1 and out_window updates (no bubble).
//  - out_window/out_last remain stable while out_valid & !out_ready.
//  - Windows never span frames: stale row data from the previous frame is present only while row_cnt<KERNEL-1, when emits are suppressed.
//  - Windows never span rows: emits are suppressed while col_cnt<KERNEL-1.
//  - Windows per frame = (IMG_W-KERNEL+1)*(IMG_H-KERNEL+1).
//  - Reset mid-frame: outputs go to reset values and counters return to 0. The next accepted pixel is treated as (0,0) of a new frame.
// CONFIGURATION
//  Macro CONV_STRIDE2_EN:
//  - Defined: an emit additionally requires (row_cnt-(KERNEL-1)) even and (col_cnt-(KERNEL-1)) even.
//    out_last marks the last such window in the frame; its position is computed from parameters at elaboration.
//    All other inputs are still accepted and shifted.
//  - Undefined: stride 1, as above.
// STRUCTURE
//  - Shared package/include: clog2 function, the window element index macro, and the counter width localparams clog2(IMG_W) and clog2(IMG_H).
//  - Sub-module: row_buffer (BIT_WIDTH, BUF_DEPTH=IMG_W), KERNEL-1 instances chained.
//    - enable = accept; write_data = previous tap (in_data for the first instance).
//  - Local logic: counters, emit/last decode, window shift register, output register.
// TESTING  (IMG_W=5, IMG_H=4, KERNEL=3, pixel value = raster index unless noted)
//  1. Stream 0..19, out_ready=1 -> exactly 6 windows.
//     First window is 1 cycle after accepting 12: rows {0,1,2},{5,6,7},{10,11,12}.
//  2. Same stream -> out_last=1 only on the 6th window {7,8,9},{12,13,14},{17,18,19}.
//  3. Hold out_ready=0 after the first window -> in_ready=0 and out_window stable for 10 cycles.
//     Release -> remaining 5 windows, no loss or duplication.
//  4. Two back-to-back frames, second frame value = 100+index -> no window mixes frames.
//     Second frame's first window is {100,101,102},{105,106,107},{110,111,112}.
//  5. Assert rst after 8 accepts -> out_valid=0 and counters 0.
//     A fresh 20-pixel frame then yields the same 6 windows as scenario 1.
//  6. CONV_STRIDE2_EN defined, stream 0..19 -> 2 windows, ending at pixels 12 and 14; out_last on the second.
//  Bench asserts in_ready == !out_valid|out_ready every cycle and checks against a golden-model scoreboard.

Source files
------------

// File: rtl/conv_window_gen_pkg.sv
// Shared helpers for the KxK sliding-window generator:
// clog2, window element index macro, default counter widths.
`ifndef CONV_WINDOW_GEN_PKG_SV
`define CONV_WINDOW_GEN_PKG_SV

// Bit offset of window element (r,c) in the flattened window bus
`define CWG_IDX(r, c, k, w) ((((r) * (k)) + (c)) * (w))

package conv_window_gen_pkg;

   localparam int DEF_BIT_WIDTH = 16;
   localparam int DEF_IMG_W     = 16;
   localparam int DEF_IMG_H     = 16;
   localparam int DEF_KERNEL    = 3;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

   localparam int DEF_COL_W = clog2(DEF_IMG_W);
   localparam int DEF_ROW_W = clog2(DEF_IMG_H);

endpackage

`endif

// File: rtl/conv_window_gen_row_buffer.sv
// One-row pixel delay: rd_data is the pixel written BUF_DEPTH
// enables ago, read from the slot about to be overwritten.
module row_buffer
   import conv_window_gen_pkg::*;
#(
   parameter int BIT_WIDTH = 16,
   parameter int BUF_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [BIT_WIDTH-1:0] wr_data,
   output logic [BIT_WIDTH-1:0] rd_data
);

   localparam int PTR_W = clog2(BUF_DEPTH);
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(BUF_DEPTH - 1);

   logic [BIT_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [PTR_W-1:0]     ptr_q;
   logic [PTR_W-1:0]     ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (en) begin
         ptr_d = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         mem_q[ptr_q] <= wr_data;
      end
   end

   assign rd_data = mem_q[ptr_q];

endmodule

// File: rtl/conv_window_gen.sv
// Line-buffer controller and KxK sliding-window generator.
// Define CONV_STRIDE2_EN to emit only every other window in both axes.
module conv_window_gen
   import conv_window_gen_pkg::*;
#(
   parameter int BIT_WIDTH = DEF_BIT_WIDTH,
   parameter int IMG_W     = DEF_IMG_W,
   parameter int IMG_H     = DEF_IMG_H,
   parameter int KERNEL    = DEF_KERNEL
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [BIT_WIDTH-1:0]                 in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [KERNEL*KERNEL*BIT_WIDTH-1:0]   out_window,
   output logic                                 out_last
);

   localparam int COL_W = clog2(IMG_W);
   localparam int ROW_W = clog2(IMG_H);
   localparam int WIN_W = KERNEL * KERNEL * BIT_WIDTH;
`ifdef CONV_STRIDE2_EN
   localparam int STRIDE = 2;
   localparam logic PAR = 1'((KERNEL - 1) % 2);
`else
   localparam int STRIDE = 1;
`endif
   localparam int LAST_R = (KERNEL - 1) + ((IMG_H - KERNEL) / STRIDE) * STRIDE;
   localparam int LAST_C = (KERNEL - 1) + ((IMG_W - KERNEL) / STRIDE) * STRIDE;

   localparam logic [COL_W-1:0] COL_MAX   = COL_W'(IMG_W - 1);
   localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL - 1);
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LAST_C);
   localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(IMG_H - 1);
   localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(LAST_R);

   logic                 accept;
   logic                 emit;
   logic                 is_last;
   logic [COL_W-1:0]     col_q, col_d;
   logic [ROW_W-1:0]     row_q, row_d;
   logic                 out_valid_q, out_valid_d;
   logic                 out_last_q, out_last_d;
   logic [WIN_W-1:0]     out_window_q, out_window_d;
   logic [BIT_WIDTH-1:0] tap   [KERNEL];
   logic [BIT_WIDTH-1:0] win_q [KERNEL][KERNEL];
   logic [BIT_WIDTH-1:0] win_d [KERNEL][KERNEL];

   assign in_ready = !out_valid_q | out_ready;
   assign accept   = in_valid & in_ready;

   // tap[i] is the pixel accepted i rows earlier
   assign tap[0] = in_data;
   for (genvar g = 1; g < KERNEL; g++) begin : g_rows
      row_buffer #(
         .BIT_WIDTH (BIT_WIDTH),
         .BUF_DEPTH (IMG_W)
      ) u_row_buffer (
         .clk     (clk),
         .rst     (rst),
         .en      (accept),
         .wr_data (tap[g-1]),
         .rd_data (tap[g])
      );
   end

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   always_comb begin
      emit = accept && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
`ifdef CONV_STRIDE2_EN
      emit = emit && (row_q[0] == PAR) && (col_q[0] == PAR);
`endif
      is_last = (row_q == ROW_LAST) && (col_q == COL_LAST);
   end

   always_comb begin
      for (int r = 0; r < KERNEL; r++) begin
         for (int c = 0; c < KERNEL - 1; c++) begin
            win_d[r][c] = win_q[r][c+1];
         end
         win_d[r][KERNEL-1] = tap[KERNEL-1-r];
      end
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      out_window_d = out_window_q;
      if (out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
      // a drain and an emit in the same cycle keep out_valid high
      if (emit) begin
         out_valid_d = 1'b1;
         out_last_d  = is_last;
         for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
               out_window_d[`CWG_IDX(r, c, KERNEL, BIT_WIDTH) +: BIT_WIDTH] =
                  win_d[r][c];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_window_q <= '0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_window_q <= out_window_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         win_q <= win_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign out_window = out_window_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on a 5x4 frame, 3x3 kernel.
// Follows CONV_STRIDE2_EN to pick the expected stride.
module tb_conv_window_gen;

   localparam int BW = 16;
   localparam int W  = 5;
   localparam int H  = 4;
   localparam int K  = 3;
   localparam int OW = K * K * BW;
`ifdef CONV_STRIDE2_EN
   localparam int STR = 2;
`else
   localparam int STR = 1;
`endif
   localparam int NWIN = ((W - K) / STR + 1) * ((H - K) / STR + 1);
   localparam int LR0  = ((H - K) / STR) * STR;
   localparam int LC0  = ((W - K) / STR) * STR;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_window;
   logic          out_last;

   conv_window_gen #(
      .BIT_WIDTH (BW),
      .IMG_W     (W),
      .IMG_H     (H),
      .KERNEL    (K)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_window (out_window),
      .out_last   (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [OW-1:0] obs,
                        input logic [OW-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic [OW-1:0] win;
      logic          last;
   } exp_t;

   exp_t          q[$];
   int            img [H][W];
   int            m_row = 0;
   int            m_col = 0;
   int            m_win = 0;
   bit            pend = 0;
   bit            stall_prev = 0;
   logic [OW-1:0] held = '0;

   int            n_out = 0;
   int            n_last = 0;
   logic [OW-1:0] first_win = '0;
   logic [OW-1:0] second_first = '0;
   logic [OW-1:0] last_flag_win = '0;

   function automatic logic [OW-1:0] mk_win(int r0, int c0, int off);
      logic [OW-1:0] v;
      v = '0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            v[(r*K+c)*BW +: BW] = BW'(off + (r0 + r) * W + c0 + c);
      return v;
   endfunction

   function automatic logic [OW-1:0] model_win(int r0, int c0);
      logic [OW-1:0] v;
      v = '0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            v[(r*K+c)*BW +: BW] = BW'(img[r0+r][c0+c]);
      return v;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q.delete();
         m_row = 0;
         m_col = 0;
         m_win = 0;
         pend = 0;
         stall_prev = 0;
      end else begin
         check("in_ready", OW'(in_ready), OW'(!out_valid | out_ready));
         if (pend) check("latency", OW'(out_valid), OW'(1));
         pend = 0;
         if (stall_prev && out_valid) check("stall_hold", out_window, held);
         held = out_window;
         stall_prev = out_valid && !out_ready;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("win_queue", OW'(q.size()), OW'(1));
            end else begin
               e = q.pop_front();
               check("window", out_window, e.win);
               check("last", OW'(out_last), OW'(e.last));
            end
            n_out++;
            if (n_out == 1) first_win = out_window;
            if (n_out == NWIN + 1) second_first = out_window;
            if (out_last) begin
               n_last++;
               last_flag_win = out_window;
            end
         end
         if (in_valid && in_ready) begin
            img[m_row][m_col] = int'(in_data);
            if (m_row >= K - 1 && m_col >= K - 1 &&
                (m_row - K + 1) % STR == 0 && (m_col - K + 1) % STR == 0) begin
               m_win++;
               e.win  = model_win(m_row - K + 1, m_col - K + 1);
               e.last = (m_win == NWIN);
               q.push_back(e);
               pend = 1;
            end
            m_col++;
            if (m_col == W) begin
               m_col = 0;
               m_row++;
               if (m_row == H) begin
                  m_row = 0;
                  m_win = 0;
               end
            end
         end
      end
   end

   task automatic send(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         int t;
         bit done;
         in_valid = 1'b1;
         in_data  = BW'(base + i);
         t = 0;
         done = 0;
         while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            if (!done) begin
               t++;
               if (t > 200) begin
                  check("send_timeout", OW'(t), OW'(0));
                  return;
               end
            end
         end
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      in_valid = 1'b0;
      while ((out_valid || q.size() != 0) && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 100) check("drain_timeout", OW'(t), OW'(0));
   endtask

   task automatic clear_stats();
      n_out = 0;
      n_last = 0;
      first_win = '0;
      second_first = '0;
      last_flag_win = '0;
   endtask

   task automatic frame_checks(input string tag);
      check({tag, "_count"}, OW'(n_out), OW'(NWIN));
      check({tag, "_nlast"}, OW'(n_last), OW'(1));
      check({tag, "_first"}, first_win, mk_win(0, 0, 0));
      check({tag, "_lastwin"}, last_flag_win, mk_win(LR0, LC0, 0));
   endtask

   initial begin
      logic [OW-1:0] hold_win;
      int t;
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", OW'(out_valid), OW'(0));
      check("rst_last", OW'(out_last), OW'(0));
      check("rst_window", out_window, OW'(0));
      check("rst_col", OW'(dut.col_q), OW'(0));
      check("rst_row", OW'(dut.row_q), OW'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;

      clear_stats();
      send(0, W * H);
      drain();
      frame_checks("s1");

      clear_stats();
      out_ready = 1'b0;
      fork
         send(0, W * H);
         begin
            t = 0;
            do begin
               @(negedge clk);
               t++;
            end while (!out_valid && t < 100);
            if (t >= 100) check("s3_wait", OW'(t), OW'(0));
            hold_win = out_window;
            check("s3_first", hold_win, mk_win(0, 0, 0));
            repeat (10) begin
               @(negedge clk);
               check("s3_in_ready", OW'(in_ready), OW'(0));
               check("s3_stable", out_window, hold_win);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      frame_checks("s3");

      clear_stats();
      send(0, W * H);
      send(100, W * H);
      drain();
      check("s4_count", OW'(n_out), OW'(2 * NWIN));
      check("s4_nlast", OW'(n_last), OW'(2));
      check("s4_second", second_first, mk_win(0, 0, 100));
      check("s4_lastwin", last_flag_win, mk_win(LR0, LC0, 100));

      clear_stats();
      send(200, 8);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("s5_valid", OW'(out_valid), OW'(0));
      check("s5_col", OW'(dut.col_q), OW'(0));
      check("s5_row", OW'(dut.row_q), OW'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      clear_stats();
      send(0, W * H);
      drain();
      frame_checks("s5");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
